// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, LSD first, start/busy/done handshake.
// Define BCD_DIGIT_CHECK_EN to add a sticky non-BCD-digit flag on output err.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout
`ifdef BCD_DIGIT_CHECK_EN
    ,
    output logic                err
`endif
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic [W-1:0]    res;
    logic            carry;
    logic [CW-1:0]   count;

    logic [4:0]      raw;
    logic [3:0]      adj;
    logic [3:0]      digit;
    logic            cnext;
    logic            last;
    logic [W-1:0]    resnext;

    // Single-digit decimal add with +6 correction; out-of-range digits follow the same rule.
    always_comb begin
        raw   = {1'b0, opa[3:0]} + {1'b0, opb[3:0]} + {4'b0000, carry};
        adj   = raw[3:0] + 4'd6;
        cnext = (raw > 5'd9);
        digit = cnext ? adj : raw[3:0];
        last  = (count == CW'(DIGITS - 1));
    end

    generate
        if (DIGITS == 1) begin : g_one
            assign resnext = digit;
        end else begin : g_many
            assign resnext = {digit, res[W-1:4]};
        end
    endgenerate

`ifdef BCD_DIGIT_CHECK_EN
    logic sticky;
    logic digflag;

    assign digflag = (opa[3:0] > 4'd9) || (opb[3:0] > 4'd9);
`endif

    // Outputs load only on the RUN->DONE transition so partial results never appear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            count <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            sticky <= 1'b0;
            err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        res   <= '0;
                        count <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                        sticky <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    opa   <= opa >> 4;
                    opb   <= opb >> 4;
                    res   <= resnext;
                    carry <= cnext;
                    count <= count + 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                    sticky <= sticky | digflag;
`endif
                    if (last) begin
                        state <= DONE;
                        sum   <= resnext;
                        cout  <= cnext;
                        done  <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                        err   <= sticky | digflag;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Digit-serial controller for a multi-digit packed-BCD adder. It sequences one single-digit BCD add per clock, LSD first, with the decimal carry held in a register between digits. One operation runs at a time, started by a start/busy/done handshake. It sits between a requester that holds two DIGITS-wide BCD operands and the single-digit BCD add/correct datapath, which is implemented inside the block.

Parameters:
DIGITS, 4, number of BCD digits per operand; legal range 1..16.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse or level; sampled only in IDLE.
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
b  input  4*DIGITS  operand B, packed BCD.
cin  input  1  carry into digit 0.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle completion pulse.
sum  output  4*DIGITS  registered result, packed BCD.
cout  output  1  decimal carry out of the most-significant digit.

Behaviour:
- States: IDLE, RUN, DONE. Digit counter is ceil(log2(DIGITS+1)) bits wide.
- Reset (rst=1 at a clock edge), in any state:
  - state goes to IDLE; busy=0, done=0, sum=0, cout=0.
  - working registers and counter are cleared.
  - Any in-flight operation is discarded; no done pulse is produced.
- IDLE:
  - If start=1 at edge T: latch a, b and cin into working shift registers; clear the counter; go to RUN.
  - If start=0: stay in IDLE.
- RUN:
  - Each cycle processes working digit i: s = a_i + b_i + c, computed 5 bits wide.
  - If s > 9: digit = (s + 6) mod 16, c_next = 1. Otherwise: digit = s, c_next = 0.
  - The result digit shifts into the working result MSD-side; operands shift right by 4 bits; the counter increments.
  - When the counter reaches DIGITS-1 while in RUN, go to DONE on the next edge.
- Cycle timing for a start sampled at edge T:
  - Digits are processed in cycles T+1 .. T+DIGITS.
  - At edge T+DIGITS+1, sum and cout load the final working result and carry, and done=1 for that single cycle.
  - The state then returns to IDLE at edge T+DIGITS+2.
  - Total latency from start to done is DIGITS+1 cycles.
- busy is 1 from T+1 through the DONE cycle inclusive.
- start while busy (RUN or DONE) is ignored; it is not queued. A start held high continuously re-triggers on the first IDLE cycle after DONE.
- sum and cout update only on entry to DONE. They hold their value through later operations until the next completion, so the outputs never show partial results.
- a, b and cin may change freely after the start edge.
- Non-BCD digits (>9) are not rejected. The same rule applies: s>9 gives correction +6 mod 16 and carry 1, so the result is defined but not meaningful.
- DIGITS=1: RUN lasts one cycle; done at T+2.

Optional Feature:
BCD_DIGIT_CHECK_EN
- Defined:
  - Extra output port err (1 bit, registered, reset 0).
  - During RUN the block ORs a per-digit flag (a_i>9 or b_i>9) into a sticky bit. The sticky bit is cleared on the start edge.
  - err loads the sticky bit on entry to DONE, alongside sum and cout, and holds it until the next completion.
  - sum and cout are still computed per the normal rule.
- Undefined: no err port; no check logic.

Test Plan:
1. DIGITS=4, reset, then start with a=0000, b=0000, cin=0 -> busy high cycles 1..5, done pulse in cycle 5 only, sum=0000, cout=0.
2. a=0006, b=0009, cin=0 -> sum=0015, cout=0; then a=0003, b=0003, cin=1 -> sum=0007.
3. a=1234, b=5678, cin=1 -> sum=6913, cout=0; then a=9999, b=0001, cin=0 -> sum=0000, cout=1. Also a=9999, b=9999, cin=1 -> sum=9999, cout=1.
4. Start an add, then pulse start again in RUN and in DONE -> exactly one done pulse, result unaffected. Assert rst in cycle 2 of RUN -> busy=0, sum=0, cout=0, no done pulse; a fresh start then completes normally.
5. Check that sum holds its previous value (e.g. 6913) throughout a following operation's RUN cycles, and changes only in that operation's DONE cycle.
6. With BCD_DIGIT_CHECK_EN: a=00A0, b=0001 -> err=1 with done. Next op a=0001, b=0001 -> err=0, sum=0002.
